// File: rtl/axis_spi_pkg.sv
// Shared types and constants for the AXIS/SPI bridge blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_spi_pkg;

  // AXI-Stream data width; narrower SPI words are right-justified into it.
  localparam int AXIS_W = 32;

  // Bit counter width, sized for the widest legal SPI word.
  localparam int CNT_W = 6;

  // Receiver frame state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RX    = 2'd2
  } rx_state_e;

  // Only whole-byte SPI words up to the AXIS width are supported.
  function automatic bit width_ok(input int w);
    return (w == 8) || (w == 16) || (w == 24) || (w == 32);
  endfunction

endpackage

// File: rtl/spi_sync_bit.sv
// N-stage single-bit synchronizer for an asynchronous SPI line.
// Latency: SYNC_STAGES clk cycles from input to output.
// Backpressure: none; samples every clk.
module spi_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/axis_spi_rx_slave.sv
// SPI mode-0 slave receiver: deserializes MOSI words (MSB first) into AXIS beats.
// Latency: tvalid rises SYNC_STAGES+1 clk edges after the final SCK high is first sampled.
// Backpressure: one output register; a word completing while it is still held is dropped (overrun).
// Optional: define AXIS_SPI_RX_OVR_CNT_EN to add the saturating 16-bit overrun_count port.
module axis_spi_rx_slave
  import axis_spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              SCK,
  input  logic              CS,
  input  logic              MOSI,
  output logic [AXIS_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
`ifdef AXIS_SPI_RX_OVR_CNT_EN
  ,
  output logic [15:0]       overrun_count
`endif
);

  if (!width_ok(SPI_DATA_WIDTH)) begin : g_bad_width
    $error("axis_spi_rx_slave: SPI_DATA_WIDTH must be 8, 16, 24 or 32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("axis_spi_rx_slave: SYNC_STAGES must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_DATA_WIDTH - 1);

  // Synchronized SPI lines.
  logic sck_s;
  logic cs_s;
  logic mosi_s;

  // Edge detection stage; MOSI is delayed alongside so it lines up with the edge pulse.
  logic sck_d;
  logic cs_d;
  logic sck_rise_q;
  logic cs_rise_q;
  logic cs_fall_q;
  logic mosi_q;

  // Frame state and deserializer.
  rx_state_e                 state_q;
  rx_state_e                 state_d;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [CNT_W-1:0]          bit_cnt_d;
  logic [SPI_DATA_WIDTH-2:0] shift_q;
  logic [SPI_DATA_WIDTH-2:0] shift_d;
  logic [SPI_DATA_WIDTH-1:0] word_w;

  logic load_word;
  logic overrun_set;
  logic frame_err_set;

  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk    (clk),
    .resetn (resetn),
    .din    (SCK),
    .dout   (sck_s)
  );

  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk    (clk),
    .resetn (resetn),
    .din    (CS),
    .dout   (cs_s)
  );

  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk    (clk),
    .resetn (resetn),
    .din    (MOSI),
    .dout   (mosi_s)
  );

  // Register edge pulses and busy; busy tracks the synchronized CS level directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_d      <= 1'b0;
      cs_d       <= 1'b0;
      sck_rise_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      mosi_q     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sck_d      <= sck_s;
      cs_d       <= cs_s;
      sck_rise_q <= sck_s & ~sck_d;
      cs_rise_q  <= cs_s & ~cs_d;
      cs_fall_q  <= ~cs_s & cs_d;
      mosi_q     <= mosi_s;
      busy       <= ~cs_s;
    end
  end

  // Completed word: the held bits plus the bit arriving on this edge.
  assign word_w = {shift_q, mosi_q};

  // Next-state and deserializer control. Reset leaves the FSM in IDLE, so a frame
  // already in progress is ignored until CS is released and asserted again.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    load_word     = 1'b0;
    overrun_set   = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_d   = ARMED;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ARMED, RX: begin
        if (cs_rise_q) begin
          state_d       = IDLE;
          bit_cnt_d     = '0;
          shift_d       = '0;
          frame_err_set = (bit_cnt_q != '0);
        end else if (sck_rise_q) begin
          state_d = RX;
          shift_d = {shift_q[SPI_DATA_WIDTH-3:0], mosi_q};
          if (bit_cnt_q == LAST_BIT) begin
            // Word boundary: realign the counter whether or not the word is kept.
            bit_cnt_d = '0;
            if (!m_axis_tvalid || m_axis_tready) begin
              load_word = 1'b1;
            end else begin
              overrun_set = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    endcase
  end

  // FSM state and deserializer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // AXIS output register and one-cycle status pulses; tdata only changes on a load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      if (load_word) begin
        m_axis_tdata  <= AXIS_W'(word_w);
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      overrun   <= overrun_set;
      frame_err <= frame_err_set;
    end
  end

`ifdef AXIS_SPI_RX_OVR_CNT_EN
  // Saturating count of dropped words, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_count <= '0;
    end else if (overrun_set && (overrun_count != 16'hFFFF)) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_spi_rx_slave.sv
// Directed bench for axis_spi_rx_slave with a scoreboard per instance (W=32, 8, 16).
// Latency: n/a (testbench).
// Backpressure: tready driven per instance by the directed steps.
module tb_axis_spi_rx_slave;

  localparam int SS = 2;

  logic clk;
  logic resetn;
  logic sck;
  logic mosi;
  logic cs0, cs1, cs2;
  logic tready0, tready1, tready2;
  logic [31:0] tdata0, tdata1, tdata2;
  logic tvalid0, tvalid1, tvalid2;
  logic busy0, busy1, busy2;
  logic ferr0, ferr1, ferr2;
  logic ovr0, ovr1, ovr2;
`ifdef AXIS_SPI_RX_OVR_CNT_EN
  logic [15:0] ocnt0, ocnt1, ocnt2;
`endif

  int errors;
  int checks;
  int beats [3];
  int ferr_n [3];
  int ovr_n [3];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] exp_q2 [$];
  logic [31:0] exp_w;

  axis_spi_rx_slave #(.SPI_DATA_WIDTH(32), .SYNC_STAGES(SS)) u_w32 (
    .clk(clk), .resetn(resetn), .SCK(sck), .CS(cs0), .MOSI(mosi),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
    .busy(busy0), .frame_err(ferr0), .overrun(ovr0)
`ifdef AXIS_SPI_RX_OVR_CNT_EN
    , .overrun_count(ocnt0)
`endif
  );

  axis_spi_rx_slave #(.SPI_DATA_WIDTH(8), .SYNC_STAGES(SS)) u_w8 (
    .clk(clk), .resetn(resetn), .SCK(sck), .CS(cs1), .MOSI(mosi),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
    .busy(busy1), .frame_err(ferr1), .overrun(ovr1)
`ifdef AXIS_SPI_RX_OVR_CNT_EN
    , .overrun_count(ocnt1)
`endif
  );

  axis_spi_rx_slave #(.SPI_DATA_WIDTH(16), .SYNC_STAGES(SS)) u_w16 (
    .clk(clk), .resetn(resetn), .SCK(sck), .CS(cs2), .MOSI(mosi),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
    .busy(busy2), .frame_err(ferr2), .overrun(ovr2)
`ifdef AXIS_SPI_RX_OVR_CNT_EN
    , .overrun_count(ocnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clk edges and land 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // MSB-first mode-0 bits, two clk per SCK phase (SCK = clk/4).
  task automatic send_bits(input logic [47:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = data[i];
      tick(2);
      sck = 1'b1;
      tick(2);
      sck = 1'b0;
    end
    tick(2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 3; i++) begin
      beats[i] = 0;
      ferr_n[i] = 0;
      ovr_n[i] = 0;
    end
    resetn = 1'b0;
    sck = 1'b0;
    mosi = 1'b0;
    cs0 = 1'b1; cs1 = 1'b1; cs2 = 1'b1;
    tready0 = 1'b0; tready1 = 1'b0; tready2 = 1'b0;

    fork
      // Scoreboard monitor: pop and compare on every handshake, tally status pulses.
      forever begin
        @(negedge clk);
        ferr_n[0] += int'(ferr0); ferr_n[1] += int'(ferr1); ferr_n[2] += int'(ferr2);
        ovr_n[0] += int'(ovr0); ovr_n[1] += int'(ovr1); ovr_n[2] += int'(ovr2);
        if (tvalid0 && tready0) begin
          beats[0]++;
          check("w32 beat expected", 32'(exp_q0.size() > 0), 32'd1);
          if (exp_q0.size() > 0) begin
            exp_w = exp_q0.pop_front();
            check("w32 tdata", tdata0, exp_w);
          end
        end
        if (tvalid1 && tready1) begin
          beats[1]++;
          check("w8 beat expected", 32'(exp_q1.size() > 0), 32'd1);
          if (exp_q1.size() > 0) begin
            exp_w = exp_q1.pop_front();
            check("w8 tdata", tdata1, exp_w);
          end
        end
        if (tvalid2 && tready2) begin
          beats[2]++;
          check("w16 beat expected", 32'(exp_q2.size() > 0), 32'd1);
          if (exp_q2.size() > 0) begin
            exp_w = exp_q2.pop_front();
            check("w16 tdata", tdata2, exp_w);
          end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state.
    tick(3);
    check("reset tvalid", 32'(tvalid0), 32'd0);
    check("reset tdata", tdata0, 32'd0);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset frame_err", 32'(ferr0), 32'd0);
    check("reset overrun", 32'(ovr0), 32'd0);
    resetn = 1'b1;
    tick(6);

    // Single 32-bit word, with exact output latency on the last bit.
    tready0 = 1'b1;
    cs0 = 1'b0;
    tick(4);
    check("w32 busy in frame", 32'(busy0), 32'd1);
    exp_q0.push_back(32'hA5C3_0F81);
    send_bits(48'(32'hA5C3_0F81 >> 1), 31);
    mosi = 1'b1;
    tick(2);
    sck = 1'b1;
    for (int k = 0; k <= SS; k++) begin
      @(posedge clk);
      #1;
      check("w32 tvalid before latency", 32'(tvalid0), 32'd0);
    end
    @(posedge clk);
    #1;
    check("w32 tvalid at latency", 32'(tvalid0), 32'd1);
    tick(1);
    sck = 1'b0;
    tick(2);
    cs0 = 1'b1;
    tick(8);
    check("w32 beats", 32'(beats[0]), 32'd1);
    check("w32 frame_err none", 32'(ferr_n[0]), 32'd0);
    check("w32 overrun none", 32'(ovr_n[0]), 32'd0);
    check("w32 busy after frame", 32'(busy0), 32'd0);

    // 8-bit width.
    tready1 = 1'b1;
    cs1 = 1'b0;
    tick(2);
    exp_q1.push_back(32'h0000_003C);
    send_bits(48'h3C, 8);
    cs1 = 1'b1;
    tick(8);
    check("w8 beats", 32'(beats[1]), 32'd1);

    // Back-to-back words with tready low: first held, two overruns.
    cs2 = 1'b0;
    tick(2);
    exp_q2.push_back(32'h0000_1234);
    send_bits(48'h1234_5678_9ABC, 48);
    cs2 = 1'b1;
    tick(8);
    check("w16 held tvalid", 32'(tvalid2), 32'd1);
    check("w16 held tdata", tdata2, 32'h0000_1234);
    check("w16 overrun pulses", 32'(ovr_n[2]), 32'd2);
    check("w16 frame_err none", 32'(ferr_n[2]), 32'd0);
`ifdef AXIS_SPI_RX_OVR_CNT_EN
    check("w16 overrun_count", 32'(ocnt2), 32'd2);
`endif
    tready2 = 1'b1;
    tick(1);
    tready2 = 1'b0;
    tick(4);
    check("w16 single delivery", 32'(beats[2]), 32'd1);
    check("w16 tvalid drained", 32'(tvalid2), 32'd0);

    // Partial frame, then a full frame.
    cs0 = 1'b0;
    tick(2);
    send_bits(48'h15, 5);
    cs0 = 1'b1;
    tick(8);
    check("partial frame_err", 32'(ferr_n[0]), 32'd1);
    check("partial no beat", 32'(beats[0]), 32'd1);
    cs0 = 1'b0;
    tick(2);
    exp_q0.push_back(32'hDEAD_BEEF);
    send_bits(48'hDEAD_BEEF, 32);
    cs0 = 1'b1;
    tick(8);
    check("after partial beats", 32'(beats[0]), 32'd2);

    // Mid-frame reset with CS held low.
    cs0 = 1'b0;
    tick(2);
    send_bits(48'h2AB, 10);
    resetn = 1'b0;
    #1;
    check("midreset tvalid", 32'(tvalid0), 32'd0);
    check("midreset tdata", tdata0, 32'd0);
    check("midreset busy", 32'(busy0), 32'd0);
    check("midreset frame_err", 32'(ferr0), 32'd0);
    check("midreset overrun", 32'(ovr0), 32'd0);
`ifdef AXIS_SPI_RX_OVR_CNT_EN
    check("midreset overrun_count", 32'(ocnt2), 32'd0);
`endif
    tick(2);
    resetn = 1'b1;
    send_bits(48'h3F_FFFF, 22);
    tick(8);
    check("midreset no tvalid", 32'(tvalid0), 32'd0);
    cs0 = 1'b1;
    tick(8);
    check("midreset no beat", 32'(beats[0]), 32'd2);
    check("midreset no frame_err", 32'(ferr_n[0]), 32'd1);
    cs0 = 1'b0;
    tick(2);
    exp_q0.push_back(32'h0000_0001);
    send_bits(48'h1, 32);
    cs0 = 1'b1;
    tick(8);
    check("after reset beats", 32'(beats[0]), 32'd3);

    // Word 2 completes on the same edge as the handshake of word 1.
    cs2 = 1'b0;
    tick(2);
    exp_q2.push_back(32'h0000_1111);
    send_bits(48'h1111, 16);
    exp_q2.push_back(32'h0000_2222);
    send_bits(48'h1111, 15);
    mosi = 1'b0;
    tick(2);
    sck = 1'b1;
    tick(3);
    tready2 = 1'b1;
    tick(1);
    tready2 = 1'b0;
    check("simul tvalid", 32'(tvalid2), 32'd1);
    check("simul tdata", tdata2, 32'h0000_2222);
    check("simul no overrun", 32'(ovr_n[2]), 32'd2);
    sck = 1'b0;
    tick(2);
    cs2 = 1'b1;
    tready2 = 1'b1;
    tick(1);
    tready2 = 1'b0;
    tick(8);
    check("simul beats", 32'(beats[2]), 32'd3);
    check("simul frame_err none", 32'(ferr_n[2]), 32'd0);

    // Everything pushed was delivered.
    check("w32 queue empty", 32'(exp_q0.size()), 32'd0);
    check("w8 queue empty", 32'(exp_q1.size()), 32'd0);
    check("w16 queue empty", 32'(exp_q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_spi_rx_slave.md
# axis_spi_rx_slave

SPI slave receiver that deserializes MOSI frames from an SPI master into AXI-Stream words. It is the receive-side counterpart of the codebase's AXIS-to-SPI transmitter and uses the same conventions: mode 0, MSB first, active-low CS, one word per `SPI_DATA_WIDTH` bits. It sits on the PL fabric clock and accepts SPI lines that are asynchronous to that clock, or driven from the same clock. It feeds a downstream AXIS consumer such as a FIFO or DMA.

## Interface
- `SPI_DATA_WIDTH`, default 32: bits per word; legal values are 8, 16, 24, 32.
- `SYNC_STAGES`, default 2: synchronizer flops on SCK, CS and MOSI; must be at least 2.
- `clk`  in  1: fabric clock.
- `resetn`  in  1: reset; **one clock; reset is asynchronous and active-low**.
- `SCK`  in  1: SPI clock; idle low.
- `CS`  in  1: chip select, active low.
- `MOSI`  in  1: serial data.
- `m_axis_tdata`  out  32: received word, right-justified, upper bits zero.
- `m_axis_tvalid`  out  1: word available.
- `m_axis_tready`  in  1: consumer ready.
- `busy`  out  1: synchronized CS is low.
- `frame_err`  out  1: one-cycle pulse when CS rises with a partial word.
- `overrun`  out  1: one-cycle pulse when a completed word is dropped.
- `overrun_count`  out  16: only present with `AXIS_SPI_RX_OVR_CNT_EN`.

## Operation
- SCK, CS and MOSI each pass through `SYNC_STAGES` flops. One extra flop on synchronized SCK and CS provides edge detection.
- **States:** IDLE, ARMED, RX.
  - IDLE → ARMED when a synchronized CS falling edge is detected.
  - ARMED/RX: each synchronized SCK rising edge shifts synchronized MOSI into the LSB of the shift register and increments `bit_cnt`. The first edge moves ARMED → RX.
  - On the bit that makes `bit_cnt == SPI_DATA_WIDTH`, form the word as {shift[W-2:0], MOSI}.
    - If the output register is empty, or it is being handed off this cycle (tvalid & tready), load the word, set tvalid, clear `bit_cnt` and stay in RX.
    - Otherwise drop the word and pulse `overrun`.
  - Multiple words per CS assertion are allowed.
  - A synchronized CS rising edge moves the FSM to IDLE and clears `bit_cnt` and the shift register. If `bit_cnt != 0`, pulse `frame_err` and discard the partial bits.
- SCK edges while CS is high are ignored.
- SCK falling edges are ignored; the master shifts MOSI on them.
- Output register: `m_axis_tvalid` stays high until a handshake. `tdata` is stable while tvalid is high and tready is low.
- After reset with CS already low, the FSM stays in IDLE. It accepts no bits until a fresh CS falling edge, so a mid-frame reset never yields misaligned words.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0.
  - `busy`=0, `frame_err`=0, `overrun`=0, `overrun_count`=0.
  - FSM in IDLE, synchronizers=0.
- SCK high and low phases must each last at least 2 clk periods. This is satisfied by the transmitter with CLK_DIV >= 4.
- Latency: `m_axis_tvalid` rises on the (SYNC_STAGES+1)th clk rising edge after the edge that first samples the final raw SCK high.
- `busy` follows raw CS with a latency of SYNC_STAGES+1 cycles.
- `frame_err` and `overrun` are exactly one clk cycle wide.
- If word completion and the consumer handshake fall in the same cycle, the new word loads and no overrun is flagged.

## Configuration
- `AXIS_SPI_RX_OVR_CNT_EN`
  - Defined: adds the `overrun_count` port, a 16-bit counter that increments on every overrun pulse. It saturates at 0xFFFF and is cleared only by reset.
  - Undefined: the port and counter are absent; `overrun` behaviour is unchanged.

## Structure
- Shared package `axis_spi_pkg` holds:
  - the legal-width check function;
  - the FSM state enum (IDLE/ARMED/RX);
  - `AXIS_W` = 32.
- One sub-module, `spi_sync_bit`: an N-stage synchronizer parameterized by `SYNC_STAGES`, instantiated three times.

## Test plan
- **Single 32-bit word:** W=32, SCK at clk/4, CS frame carrying 0xA5C3_0F81, tready=1 → exactly one beat with tdata=0xA5C3_0F81; `frame_err`=0, `overrun`=0.
- **8-bit width:** W=8, frame 0x3C → tdata=0x0000_003C.
- **Back-to-back and overrun:** W=16, one CS frame with 3 words 0x1234, 0x5678, 0x9ABC, tready held 0 → 0x1234 held, two `overrun` pulses, `overrun_count`=2 when the macro is defined. After tready goes high, 0x1234 is delivered and nothing else.
- **Partial frame:** CS rises after 5 bits → one `frame_err` pulse and no beat. A following full frame 0xDEADBEEF is received correctly.
- **Mid-frame reset:** resetn pulsed low after bit 10 while CS stays low → all outputs at reset values and no beat for the remainder. The next CS frame 0x0000_0001 is received correctly.
- **Simultaneous events:** word 2 completes in the same cycle as the handshake of word 1 → both delivered, no overrun.
